// File: rtl/dmac_write_burst_splitter.sv
// Splits one per-channel DMA write command into AXI4 write-address requests
// that respect MAX_BURST_LEN, the BOUNDARY window and the 16-beat FIXED limit.
module dmac_write_burst_splitter #(
  parameter int ADDR_WD       = 32,
  parameter int DATA_WD       = 32,
  parameter int CHANNEL_COUNT = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int BOUNDARY      = 4096,
  localparam int STRB_WD      = DATA_WD / 8,
  localparam int ID_WD        = $clog2(CHANNEL_COUNT),
  localparam int OFF_WD       = $clog2(STRB_WD),
  localparam int BURST_BITS   = 2,
  localparam int LEN_BITS     = 8,
  localparam int SIZE_BITS    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_in_valid,
  output logic                  cmd_in_ready,
  input  logic [ID_WD-1:0]      cmd_in_id,
  input  logic [OFF_WD-1:0]     cmd_in_src_offset,
  input  logic [ADDR_WD-1:0]    cmd_in_dst_addr,
  input  logic [1:0]            cmd_in_burst,
  input  logic [ADDR_WD-1:0]    cmd_in_len,
  input  logic [2:0]            cmd_in_size,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [ID_WD-1:0]      wr_req_id,
  output logic [ADDR_WD-1:0]    wr_req_addr,
  output logic [BURST_BITS-1:0] wr_req_burst,
  output logic [LEN_BITS-1:0]   wr_req_len,
  output logic [SIZE_BITS-1:0]  wr_req_size,
  output logic [OFF_WD-1:0]     wr_req_data_offset,
  output logic                  wr_req_last,
  output logic                  cmd_done,
  output logic [1:0]            dbg_state
);

  localparam int RW = ADDR_WD + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, ISSUE = 2'd2} state_t;
  state_t state, state_nxt;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the sender holds every field stable while valid is high and ready is low.
  logic cmd_hs, req_hs;
  assign cmd_hs = cmd_in_valid && cmd_in_ready;
  assign req_hs = wr_req_valid && wr_req_ready;

  logic [ADDR_WD-1:0] cur_addr;
  logic [RW-1:0]      rem_beats, beats_q, beats_nxt;
  logic               fixed_q;

  // Beat count of the new command, including the partial leading beat.
  logic [RW-1:0]      in_mask, in_sum, in_rem;
  logic [ADDR_WD-1:0] in_lo;
  assign in_mask = (RW'(1) << cmd_in_size) - RW'(1);
  assign in_lo   = cmd_in_dst_addr & ADDR_WD'(in_mask);
  assign in_sum  = {1'b0, cmd_in_len} + {1'b0, in_lo};
  assign in_rem  = (in_sum >> cmd_in_size) + RW'(|(in_sum & in_mask));

  // Room to the boundary is measured from the beat-aligned address so an
  // unaligned start near the boundary still counts its partial beat.
  logic [ADDR_WD-1:0] aligned, bnd_off;
  logic [RW-1:0]      to_bnd;
  assign aligned = cur_addr & ~((ADDR_WD'(1) << wr_req_size) - ADDR_WD'(1));
  assign bnd_off = aligned & ADDR_WD'(BOUNDARY - 1);
  assign to_bnd  = (RW'(BOUNDARY) - RW'(bnd_off)) >> wr_req_size;

  always_comb begin
    beats_nxt = rem_beats;
    if (fixed_q) begin
      if (beats_nxt > RW'(16)) beats_nxt = RW'(16);
    end else begin
      if (beats_nxt > RW'(MAX_BURST_LEN)) beats_nxt = RW'(MAX_BURST_LEN);
      if (beats_nxt > to_bnd) beats_nxt = to_bnd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_hs && (cmd_in_len != '0)) state_nxt = PREP;
      PREP:    state_nxt = ISSUE;
      ISSUE:   if (req_hs) state_nxt = wr_req_last ? IDLE : PREP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_in_ready = (state == IDLE);
    wr_req_valid = (state == ISSUE);
    dbg_state    = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr           <= '0;
      rem_beats          <= '0;
      beats_q            <= '0;
      fixed_q            <= 1'b0;
      wr_req_id          <= '0;
      wr_req_addr        <= '0;
      wr_req_burst       <= '0;
      wr_req_len         <= '0;
      wr_req_size        <= '0;
      wr_req_data_offset <= '0;
      wr_req_last        <= 1'b0;
      cmd_done           <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      case (state)
        IDLE: if (cmd_hs) begin
          wr_req_id          <= cmd_in_id;
          wr_req_burst       <= cmd_in_burst;
          wr_req_size        <= cmd_in_size;
          wr_req_data_offset <= cmd_in_src_offset;
          cur_addr           <= cmd_in_dst_addr;
          rem_beats          <= in_rem;
          fixed_q            <= (cmd_in_burst == 2'd0);
          cmd_done           <= (cmd_in_len == '0);
        end
        PREP: begin
          wr_req_addr <= cur_addr;
          wr_req_len  <= LEN_BITS'(beats_nxt - RW'(1));
          wr_req_last <= (beats_nxt == rem_beats);
          beats_q     <= beats_nxt;
        end
        ISSUE: if (req_hs) begin
          rem_beats <= rem_beats - beats_q;
          if (!fixed_q) cur_addr <= aligned + ADDR_WD'(beats_q << wr_req_size);
          cmd_done  <= wr_req_last;
        end
        default: ;
      endcase
    end
  end

endmodule
